// File: rtl/io_port_bank_if.sv
// rtl/io_port_bank_if.sv - CPU data-bus bundle between the core and the I/O port bank
interface io_port_bank_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output addr, wdata, we, re,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, rvalid
    );
endinterface

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - memory-mapped output registers, synchronised inputs, change detect and irq
module io_port_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 4,
    parameter int IO_SEL_BIT = 7
) (
    input  logic                          clock,
    input  logic                          reset,
    io_port_bank_if.slave                 bus,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_ports,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_ports,
    output logic                          irq
);
    localparam logic [4:0] IN_BASE    = 5'd8;
    localparam logic [4:0] CHG_OFF    = 5'd16;
    localparam logic [4:0] IRQ_EN_OFF = 5'd17;
    localparam logic [4:0] ID_OFF     = 5'd18;
    localparam logic [DATA_WIDTH-1:0] ID_VALUE =
        DATA_WIDTH'({16'h10B0, 8'(NUM_IN), 8'(NUM_OUT)});

    logic [NUM_OUT-1:0][DATA_WIDTH-1:0] out_q;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0]  sync1_q;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0]  sync2_q;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0]  prev_q;
    logic [NUM_IN-1:0]                  chg_q;
    logic [NUM_IN-1:0]                  irq_en_q;
    logic [NUM_IN-1:0]                  chg_set;
    logic [NUM_IN-1:0]                  chg_clr;
    logic [1:0]                         settle_q;
    logic [DATA_WIDTH-1:0]              rd_mux;
    logic [4:0]                         offset;
    logic                               hit;
    logic                               wr;
    logic                               rd;
    logic                               unused_addr;

    assign hit         = bus.addr[IO_SEL_BIT];
    assign offset      = bus.addr[6:2];
    assign wr          = bus.we & hit;
    assign rd          = bus.re & hit;
    assign unused_addr = ^bus.addr;
    assign out_ports   = out_q;

    // Change detection is held off until the zero-filled pipeline has flushed after reset.
    always_comb begin
        chg_set = '0;
        chg_clr = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            chg_set[k] = (sync2_q[k] != prev_q[k]) && (settle_q == 2'd0);
        end
        if (wr && (offset == CHG_OFF)) begin
            chg_clr = bus.wdata[NUM_IN-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (offset == 5'(k)) rd_mux = out_q[k];
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (offset == IN_BASE + 5'(k)) rd_mux = sync2_q[k];
        end
        if (offset == CHG_OFF)    rd_mux = DATA_WIDTH'(chg_q);
        if (offset == IRQ_EN_OFF) rd_mux = DATA_WIDTH'(irq_en_q);
        if (offset == ID_OFF)     rd_mux = ID_VALUE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            chg_q      <= '0;
            irq_en_q   <= '0;
            settle_q   <= 2'd3;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            sync1_q <= in_ports;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
            // A set landing on the same edge as its clear wins.
            chg_q      <= (chg_q & ~chg_clr) | chg_set;
            irq        <= |(chg_q & irq_en_q);
            bus.rvalid <= rd;
            if (rd) bus.rdata <= rd_mux;
            if (wr) begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (offset == 5'(k)) out_q[k] <= bus.wdata;
                end
                if (offset == IRQ_EN_OFF) irq_en_q <= bus.wdata[NUM_IN-1:0];
            end
        end
    end
endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - directed self-checking bench for io_port_bank
module tb_io_port_bank;
    localparam int DW = 32;
    localparam logic [31:0] A_OUT0   = 32'h80;
    localparam logic [31:0] A_OUT1   = 32'h84;
    localparam logic [31:0] A_IN2    = 32'hA8;
    localparam logic [31:0] A_IN3    = 32'hAC;
    localparam logic [31:0] A_CHG    = 32'hC0;
    localparam logic [31:0] A_IRQ_EN = 32'hC4;
    localparam logic [31:0] A_ID     = 32'hC8;
    localparam logic [31:0] A_UNMAP  = 32'hE4;

    logic           clock;
    logic           reset;
    logic [127:0]   in_ports;
    logic [127:0]   out_ports;
    logic           irq;
    int             tests_run;
    int             tests_failed;

    io_port_bank_if #(.DATA_WIDTH(DW)) bus ();

    io_port_bank #(
        .DATA_WIDTH(DW), .NUM_IN(4), .NUM_OUT(4), .IO_SEL_BIT(7)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .in_ports (in_ports),
        .out_ports(out_ports),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        bus.re   = 1'b1;
        tick();
        bus.re   = 1'b0;
        check({tag, ".rvalid"}, 128'(bus.rvalid), 128'(1'b1));
        check(tag, 128'(bus.rdata), 128'(exp));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        in_ports     = {32'h77, 32'h0, 32'h0, 32'h1};
        reset        = 1'b1;

        // reset state and ID
        repeat (2) tick();
        check("rst.out_ports", out_ports, 128'h0);
        check("rst.irq", 128'(irq), 128'h0);
        check("rst.rvalid", 128'(bus.rvalid), 128'h0);
        reset = 1'b0;
        repeat (6) tick();
        check("post.out_ports", out_ports, 128'h0);
        check("post.irq", 128'(irq), 128'h0);
        read_check("post.chg", A_CHG, 32'h0);
        read_check("id", A_ID, 32'h10B0_0404);
        tick();
        check("id.rvalid_drop", 128'(bus.rvalid), 128'h0);
        check("id.rdata_hold", 128'(bus.rdata), 128'h10B0_0404);
        read_check("in3", A_IN3, 32'h77);

        // output write, readback, and a miss that must change nothing
        bus_write(A_OUT1, 32'hDEAD_BEEF);
        check("out1.port", out_ports, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0});
        read_check("out1.rb", A_OUT1, 32'hDEAD_BEEF);
        bus_write(32'h04, 32'h1234_5678);
        check("miss.write", out_ports, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0});
        bus.addr = 32'h04;
        bus.re   = 1'b1;
        tick();
        bus.re   = 1'b0;
        check("miss.rvalid", 128'(bus.rvalid), 128'h0);

        // input latency: sync2 after 2 edges, CHG on the 3rd
        in_ports[95:64] = 32'h5A;
        read_check("in2.e1", A_IN2, 32'h0);
        read_check("in2.e2", A_IN2, 32'h0);
        read_check("chg.e3", A_CHG, 32'h0);
        read_check("chg.e4", A_CHG, 32'h4);
        read_check("in2.e5", A_IN2, 32'h5A);
        check("irq.masked", 128'(irq), 128'h0);

        // interrupt path
        bus_write(A_CHG, 32'h4);
        read_check("chg.cleared", A_CHG, 32'h0);
        bus_write(A_IRQ_EN, 32'hFFFF_FFFF);
        read_check("irq_en.width", A_IRQ_EN, 32'hF);
        bus_write(A_IRQ_EN, 32'h4);
        in_ports[95:64] = 32'hA5;
        repeat (3) tick();
        check("irq.at_chg", 128'(irq), 128'h0);
        tick();
        check("irq.set", 128'(irq), 128'h1);
        bus_write(A_CHG, 32'h4);
        check("irq.clr_edge", 128'(irq), 128'h1);
        tick();
        check("irq.cleared", 128'(irq), 128'h0);
        read_check("chg2.cleared", A_CHG, 32'h0);

        // W1C of CHG[0] on the same edge a new change sets it
        in_ports[31:0] = 32'h2;
        repeat (2) tick();
        bus_write(A_CHG, 32'h1);
        read_check("collide.chg", A_CHG, 32'h1);
        check("collide.irq", 128'(irq), 128'h0);
        bus_write(A_CHG, 32'h1);
        read_check("w1c.chg", A_CHG, 32'h0);

        // read/write same offset, then unmapped offset
        bus_write(A_OUT0, 32'h11);
        bus.addr  = A_OUT0;
        bus.wdata = 32'h22;
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        check("rw.rvalid", 128'(bus.rvalid), 128'h1);
        check("rw.rdata", 128'(bus.rdata), 128'h11);
        check("rw.out0", out_ports, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h22});
        read_check("unmapped", A_UNMAP, 32'h0);
        bus_write(A_UNMAP, 32'hFFFF_FFFF);
        check("unmapped.write", out_ports, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h22});

        // reset mid-operation with a read pending
        bus.addr = A_ID;
        bus.re   = 1'b1;
        reset    = 1'b1;
        in_ports = {32'h1, 32'h2, 32'h3, 32'h4};
        tick();
        bus.re   = 1'b0;
        check("mid.rvalid", 128'(bus.rvalid), 128'h0);
        check("mid.out_ports", out_ports, 128'h0);
        reset = 1'b0;
        repeat (6) tick();
        read_check("mid.chg", A_CHG, 32'h0);
        read_check("mid.irq_en", A_IRQ_EN, 32'h0);
        check("mid.irq", 128'(irq), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised memory-mapped I/O bank; successor to the fixed four-in/four-out port logic inside the data-memory block.
- Decodes the CPU data address (alu result) in the I/O region and provides NUM_OUT write/readback output registers and NUM_IN synchronised input ports.
- Adds per-input change detection, a sticky write-1-to-clear status register, a masked interrupt, a registered read path and a config ID register.
- Sits beside data memory; its rdata is muxed onto memout by the top level.

Parameters:
- DATA_WIDTH, 32, width of every port, register and bus word.
- NUM_IN, 4, number of input ports, 1..8.
- NUM_OUT, 4, number of output ports, 1..8.
- IO_SEL_BIT, 7, address bit that selects the I/O region when 1.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  DATA_WIDTH  byte address from CPU; bits [6:2] give the word offset.
- wdata  in  DATA_WIDTH  write data.
- we  in  1  write strobe.
- re  in  1  read strobe.
- rdata  out  DATA_WIDTH  registered read data.
- rvalid  out  1  one-cycle pulse, rdata valid.
- in_ports  in  NUM_IN*DATA_WIDTH  asynchronous inputs; port k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_ports  out  NUM_OUT*DATA_WIDTH  output registers, same packing as in_ports.
- irq  out  1  level interrupt.

Behaviour:
- Reset (synchronous, active-high):
  - All output registers, rdata, rvalid, irq, CHG, IRQ_EN, synchroniser flops and prev-sample registers go to 0.
  - The settle counter loads 3.
- Hit condition: addr[IO_SEL_BIT]==1. With no hit, we and re are ignored, no state changes, and rvalid=0.
- Register map (offset = addr[6:2]):
  - 0..NUM_OUT-1: OUT[k], read/write.
  - 8..8+NUM_IN-1: IN[k], read-only; holds the synchronised value.
  - 16: CHG[NUM_IN-1:0], sticky, write-1-to-clear.
  - 17: IRQ_EN[NUM_IN-1:0], read/write.
  - 18: ID, read-only = {16'h10B0, NUM_IN[7:0], NUM_OUT[7:0]}.
  - Any other offset reads 0; writes to it are ignored.
  - Bits above NUM_IN in CHG and IRQ_EN read 0.
- Write: with we && hit, the target register updates at the next edge. out_ports reflects the new value the cycle after the write edge.
- Read: with re && hit at edge N, rdata and rvalid are set at edge N; rvalid deasserts at N+1 unless re is held. rdata holds its last value while rvalid=0.
- Read and write in the same cycle to the same offset: rdata returns the pre-write value.
- Input path:
  - Two-flop synchroniser per port: sync1 <= in, sync2 <= sync1. IN[k] = sync2.
  - prev[k] <= sync2 every cycle.
  - Latency: an input change is visible in IN[k] 2 edges later; CHG[k] sets on the 3rd edge.
- Change detect: CHG[k] sets when sync2[k] != prev[k] and the settle counter is 0.
  - The settle counter decrements from 3 to 0 after reset release, suppressing spurious changes from the 0-initialised pipeline.
- Simultaneous set and W1C on the same CHG bit in one cycle: set wins and the bit stays 1.
- irq: registered, irq <= |(CHG & IRQ_EN), i.e. one edge after the CHG or IRQ_EN update.
- Reset asserted mid-operation: every register returns to its reset value at that edge, a pending read is dropped (rvalid=0), and the settle window restarts.

Test Plan:
- Reset/ID: assert reset for 2 cycles with in_ports nonzero, release, wait 6 cycles -> out_ports=0, CHG reads 0, irq=0. Read addr 0x80+18*4 -> rdata=0x10B00404 with rvalid 1 cycle after re.
- Output write: write 0xDEADBEEF to 0x84 (OUT1) -> out_ports[63:32]=0xDEADBEEF the cycle after; readback returns same; a write to 0x04 (no hit) leaves all out_ports unchanged.
- Input sync/latency: step in_port2 from 0 to 0x5A at edge T -> IN2 (0xA8) reads 0x5A from T+2; CHG bit2 set at T+3; irq remains 0 while IRQ_EN=0.
- Interrupt: write IRQ_EN=0x4, toggle in_port2 -> irq=1 one edge after CHG[2]; write CHG=0x4 -> CHG[2]=0 and irq=0 on the following edge.
- Set/clear collision: arrange for the W1C of CHG[0] to land on the same edge where a new in_port0 change sets it -> CHG[0] stays 1.
- Collision and unmapped: re+we to OUT0 in the same cycle with old value 0x11 and new 0x22 -> rdata=0x11, OUT0=0x22; read offset 25 -> rdata=0, rvalid=1.
